// File: rtl/nf2_dma_que_mux_if.sv
// Bus bundle between the DMA sync FIFOs and the CPU queues.
// master is the mux's view; slave is the surrounding FIFOs/queues.
interface nf2_dma_que_mux_if #(
    parameter int NUM_CPU_QUEUES = 8,
    parameter int DMA_DATA_WIDTH = 32,
    parameter int DMA_CTRL_WIDTH = DMA_DATA_WIDTH / 8,
    parameter int VB_WIDTH       = 2,
    parameter int QID_WIDTH      = 4,
    parameter int PKT_LEN_WIDTH  = 12
);
    logic                                     enable_dma;
    logic                                     txfifo_empty;
    logic                                     txfifo_rd_is_req;
    logic                                     txfifo_rd_pkt_vld;
    logic                                     txfifo_rd_type_eop;
    logic [VB_WIDTH-1:0]                      txfifo_rd_valid_bytes;
    logic [DMA_DATA_WIDTH-1:0]                txfifo_rd_data;
    logic                                     txfifo_rd_inc;
    logic                                     rxfifo_nearly_full;
    logic                                     rxfifo_wr;
    logic                                     rxfifo_wr_eop;
    logic [VB_WIDTH-1:0]                      rxfifo_wr_valid_bytes;
    logic [DMA_DATA_WIDTH-1:0]                rxfifo_wr_data;
    logic [NUM_CPU_QUEUES-1:0]                cpu_q_dma_rd;
    logic [NUM_CPU_QUEUES*DMA_DATA_WIDTH-1:0] cpu_q_dma_rd_data;
    logic [NUM_CPU_QUEUES*DMA_CTRL_WIDTH-1:0] cpu_q_dma_rd_ctrl;
    logic [NUM_CPU_QUEUES-1:0]                cpu_q_dma_rd_empty;
    logic [NUM_CPU_QUEUES-1:0]                cpu_q_dma_nearly_full;
    logic [NUM_CPU_QUEUES-1:0]                cpu_q_dma_wr;
    logic                                     cpu_q_dma_wr_pkt_vld;
    logic [DMA_DATA_WIDTH-1:0]                cpu_q_dma_wr_data;
    logic [DMA_CTRL_WIDTH-1:0]                cpu_q_dma_wr_ctrl;
    logic                                     pkt_ingress;
    logic                                     pkt_egress;
    logic                                     pkt_drop;
    logic                                     req_err;
    logic [QID_WIDTH-1:0]                     pkt_qid;
    logic [PKT_LEN_WIDTH-1:0]                 pkt_len;

    modport master (
        input  enable_dma, txfifo_empty, txfifo_rd_is_req, txfifo_rd_pkt_vld,
               txfifo_rd_type_eop, txfifo_rd_valid_bytes, txfifo_rd_data,
               rxfifo_nearly_full, cpu_q_dma_rd_data, cpu_q_dma_rd_ctrl,
               cpu_q_dma_rd_empty, cpu_q_dma_nearly_full,
        output txfifo_rd_inc, rxfifo_wr, rxfifo_wr_eop, rxfifo_wr_valid_bytes,
               rxfifo_wr_data, cpu_q_dma_rd, cpu_q_dma_wr, cpu_q_dma_wr_pkt_vld,
               cpu_q_dma_wr_data, cpu_q_dma_wr_ctrl, pkt_ingress, pkt_egress,
               pkt_drop, req_err, pkt_qid, pkt_len
    );

    modport slave (
        output enable_dma, txfifo_empty, txfifo_rd_is_req, txfifo_rd_pkt_vld,
               txfifo_rd_type_eop, txfifo_rd_valid_bytes, txfifo_rd_data,
               rxfifo_nearly_full, cpu_q_dma_rd_data, cpu_q_dma_rd_ctrl,
               cpu_q_dma_rd_empty, cpu_q_dma_nearly_full,
        input  txfifo_rd_inc, rxfifo_wr, rxfifo_wr_eop, rxfifo_wr_valid_bytes,
               rxfifo_wr_data, cpu_q_dma_rd, cpu_q_dma_wr, cpu_q_dma_wr_pkt_vld,
               cpu_q_dma_wr_data, cpu_q_dma_wr_ctrl, pkt_ingress, pkt_egress,
               pkt_drop, req_err, pkt_qid, pkt_len
    );
endinterface

// File: rtl/nf2_dma_que_mux.sv
// DMA <-> CPU queue mux/demux: steers tx FIFO packets into one of N CPU queues
// and drains a selected CPU queue into the rx FIFO, with qid range checking.
module nf2_dma_que_mux #(
    parameter int NUM_CPU_QUEUES = 8,
    parameter int DMA_DATA_WIDTH = 32,
    parameter int DMA_CTRL_WIDTH = DMA_DATA_WIDTH / 8,
    parameter int VB_WIDTH       = 2,
    parameter int QID_WIDTH      = 4,
    parameter int PKT_LEN_WIDTH  = 12
) (
    input logic               clk,
    input logic               reset,
    nf2_dma_que_mux_if.master bus
);
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_TX      = 2'd1,
        ST_TX_DROP = 2'd2,
        ST_RX      = 2'd3
    } state_t;

    localparam logic [QID_WIDTH:0] NUM_Q_L = (QID_WIDTH+1)'(NUM_CPU_QUEUES);

    // valid_bytes n (0 = full word) -> one-hot bit n-1; the wrap of vb-1 yields the MSB for 0
    function automatic logic [DMA_CTRL_WIDTH-1:0] vb_to_ctrl(input logic [VB_WIDTH-1:0] vb);
        logic [VB_WIDTH-1:0] idx;
        idx        = vb - VB_WIDTH'(1'b1);
        vb_to_ctrl = '0;
        for (int i = 0; i < DMA_CTRL_WIDTH; i++) begin
            vb_to_ctrl[i] = (idx == VB_WIDTH'(i));
        end
    endfunction

    function automatic logic [VB_WIDTH-1:0] ctrl_to_vb(input logic [DMA_CTRL_WIDTH-1:0] ctrl);
        ctrl_to_vb = '0;
        for (int i = 0; i < DMA_CTRL_WIDTH; i++) begin
            if (ctrl[i]) ctrl_to_vb = VB_WIDTH'(i + 1);
        end
    endfunction

    state_t                    state_q, state_d;
    logic                      first_word_q, first_word_d;
    logic [QID_WIDTH-1:0]      pkt_qid_q, pkt_qid_d;
    logic [PKT_LEN_WIDTH-1:0]  pkt_len_q, pkt_len_d;
    logic [NUM_CPU_QUEUES-1:0] wr_q, wr_d;
    logic                      wr_vld_q, wr_vld_d;
    logic [DMA_DATA_WIDTH-1:0] wr_data_q, wr_data_d;
    logic [DMA_CTRL_WIDTH-1:0] wr_ctrl_q, wr_ctrl_d;
    logic                      ingress_q, ingress_d;
    logic                      egress_q, egress_d;
    logic                      drop_q, drop_d;
    logic                      req_err_q, req_err_d;

    logic [NUM_CPU_QUEUES-1:0] qsel_s;
    logic [DMA_DATA_WIDTH-1:0] head_data_s;
    logic [DMA_CTRL_WIDTH-1:0] head_ctrl_s;
    logic                      sel_nf_s, sel_empty_s, qid_ok_s;
    logic [QID_WIDTH-1:0]      req_qid_s;
    logic                      rd_inc_s, rx_wr_s;
    logic [NUM_CPU_QUEUES-1:0] rd_s;

    // Decode the latched qid and select that queue's head word and flags
    always_comb begin
        qsel_s      = '0;
        head_data_s = '0;
        head_ctrl_s = '0;
        for (int i = 0; i < NUM_CPU_QUEUES; i++) begin
            qsel_s[i]   = (pkt_qid_q == QID_WIDTH'(i));
            head_data_s = head_data_s |
                (bus.cpu_q_dma_rd_data[i*DMA_DATA_WIDTH +: DMA_DATA_WIDTH] & {DMA_DATA_WIDTH{qsel_s[i]}});
            head_ctrl_s = head_ctrl_s |
                (bus.cpu_q_dma_rd_ctrl[i*DMA_CTRL_WIDTH +: DMA_CTRL_WIDTH] & {DMA_CTRL_WIDTH{qsel_s[i]}});
        end
        sel_nf_s    = |(bus.cpu_q_dma_nearly_full & qsel_s);
        sel_empty_s = |(bus.cpu_q_dma_rd_empty & qsel_s);
        req_qid_s   = bus.txfifo_rd_data[QID_WIDTH-1:0];
        qid_ok_s    = ({1'b0, req_qid_s} < NUM_Q_L);
    end

    // Next-state, pop/strobe decisions and registered-output updates
    always_comb begin
        state_d      = state_q;
        first_word_d = first_word_q;
        pkt_qid_d    = pkt_qid_q;
        pkt_len_d    = pkt_len_q;
        wr_d         = '0;
        wr_vld_d     = wr_vld_q;
        wr_data_d    = wr_data_q;
        wr_ctrl_d    = wr_ctrl_q;
        ingress_d    = 1'b0;
        egress_d     = 1'b0;
        drop_d       = 1'b0;
        req_err_d    = 1'b0;
        rd_inc_s     = 1'b0;
        rx_wr_s      = 1'b0;
        rd_s         = '0;
        case (state_q)
            ST_IDLE: begin
                if (bus.enable_dma && !bus.txfifo_empty) begin
                    rd_inc_s = 1'b1;
                    if (bus.txfifo_rd_is_req) begin
                        pkt_qid_d    = req_qid_s;
                        first_word_d = 1'b1;
                        if (!bus.txfifo_rd_type_eop) begin
                            state_d = qid_ok_s ? ST_TX : ST_TX_DROP;
                        end else if (qid_ok_s) begin
                            state_d = ST_RX;
                        end else begin
                            req_err_d = 1'b1;
                        end
                    end else begin
                        req_err_d = 1'b1;
                    end
                end else begin
                    rd_inc_s = 1'b0;
                end
            end
            ST_TX: begin
                if (!bus.txfifo_empty && !sel_nf_s) begin
                    rd_inc_s     = 1'b1;
                    wr_d         = qsel_s;
                    wr_vld_d     = bus.txfifo_rd_pkt_vld;
                    wr_data_d    = bus.txfifo_rd_data;
                    wr_ctrl_d    = bus.txfifo_rd_type_eop ? vb_to_ctrl(bus.txfifo_rd_valid_bytes)
                                                          : {DMA_CTRL_WIDTH{1'b0}};
                    first_word_d = 1'b0;
                    pkt_len_d    = first_word_q ? bus.txfifo_rd_data[PKT_LEN_WIDTH-1:0] : pkt_len_q;
                    if (bus.txfifo_rd_type_eop) begin
                        state_d   = ST_IDLE;
                        ingress_d = 1'b1;
                    end else begin
                        state_d = ST_TX;
                    end
                end else begin
                    rd_inc_s = 1'b0;
                end
            end
            ST_TX_DROP: begin
                if (!bus.txfifo_empty) begin
                    rd_inc_s = 1'b1;
                    if (bus.txfifo_rd_type_eop) begin
                        state_d = ST_IDLE;
                        drop_d  = 1'b1;
                    end else begin
                        state_d = ST_TX_DROP;
                    end
                end else begin
                    rd_inc_s = 1'b0;
                end
            end
            ST_RX: begin
                if (!bus.rxfifo_nearly_full && !sel_empty_s) begin
                    rd_s         = qsel_s;
                    rx_wr_s      = 1'b1;
                    first_word_d = 1'b0;
                    pkt_len_d    = first_word_q ? head_data_s[PKT_LEN_WIDTH-1:0] : pkt_len_q;
                    if (|head_ctrl_s) begin
                        state_d  = ST_IDLE;
                        egress_d = 1'b1;
                    end else begin
                        state_d = ST_RX;
                    end
                end else begin
                    rx_wr_s = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            first_word_q <= 1'b1;
            pkt_qid_q    <= '0;
            pkt_len_q    <= '0;
            wr_q         <= '0;
            wr_vld_q     <= 1'b0;
            wr_data_q    <= '0;
            wr_ctrl_q    <= '0;
            ingress_q    <= 1'b0;
            egress_q     <= 1'b0;
            drop_q       <= 1'b0;
            req_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            first_word_q <= first_word_d;
            pkt_qid_q    <= pkt_qid_d;
            pkt_len_q    <= pkt_len_d;
            wr_q         <= wr_d;
            wr_vld_q     <= wr_vld_d;
            wr_data_q    <= wr_data_d;
            wr_ctrl_q    <= wr_ctrl_d;
            ingress_q    <= ingress_d;
            egress_q     <= egress_d;
            drop_q       <= drop_d;
            req_err_q    <= req_err_d;
        end
    end

    // Combinational strobes are held off during reset so no FIFO is touched
    assign bus.txfifo_rd_inc         = rd_inc_s & ~reset;
    assign bus.rxfifo_wr             = rx_wr_s & ~reset;
    assign bus.cpu_q_dma_rd          = rd_s & {NUM_CPU_QUEUES{~reset}};
    assign bus.rxfifo_wr_data        = head_data_s;
    assign bus.rxfifo_wr_eop         = |head_ctrl_s;
    assign bus.rxfifo_wr_valid_bytes = ctrl_to_vb(head_ctrl_s);
    assign bus.cpu_q_dma_wr          = wr_q;
    assign bus.cpu_q_dma_wr_pkt_vld  = wr_vld_q;
    assign bus.cpu_q_dma_wr_data     = wr_data_q;
    assign bus.cpu_q_dma_wr_ctrl     = wr_ctrl_q;
    assign bus.pkt_ingress           = ingress_q;
    assign bus.pkt_egress            = egress_q;
    assign bus.pkt_drop              = drop_q;
    assign bus.req_err               = req_err_q;
    assign bus.pkt_qid               = pkt_qid_q;
    assign bus.pkt_len               = pkt_len_q;
endmodule

// File: tb/tb_nf2_dma_que_mux.sv
// Randomized bench: host-level packet model for the tx FIFO and CPU queues,
// with scoreboards for queue writes, rx FIFO writes and statistics pulses.
module tb_nf2_dma_que_mux;
    localparam int NQ = 8, DW = 32, CW = 4, VBW = 2, QW = 4, LW = 12;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    nf2_dma_que_mux_if #(.NUM_CPU_QUEUES(NQ), .DMA_DATA_WIDTH(DW), .DMA_CTRL_WIDTH(CW),
                         .VB_WIDTH(VBW), .QID_WIDTH(QW), .PKT_LEN_WIDTH(LW)) bus ();

    nf2_dma_que_mux #(.NUM_CPU_QUEUES(NQ), .DMA_DATA_WIDTH(DW), .DMA_CTRL_WIDTH(CW),
                      .VB_WIDTH(VBW), .QID_WIDTH(QW), .PKT_LEN_WIDTH(LW)) dut (
        .clk(clk), .reset(reset), .bus(bus));

    typedef struct packed {
        logic           is_req;
        logic           vld;
        logic           te;
        logic [VBW-1:0] vb;
        logic [DW-1:0]  data;
    } tx_ent_t;

    tx_ent_t            txq[$];
    logic [CW+DW-1:0]   srcq[$];
    logic [QW+1+CW+DW-1:0] exp_tx[$], got_tx[$];
    logic [1+VBW+DW-1:0]   exp_rx[$], got_rx[$];

    int n_checks = 0, n_errors = 0;
    int exp_ing = 0, exp_egr = 0, exp_drop = 0, exp_err = 0;
    int cnt_ing = 0, cnt_egr = 0, cnt_drop = 0, cnt_err = 0;
    int viol = 0;
    logic [QW-1:0] exp_qid = '0;
    logic [LW-1:0] exp_len = '0;
    logic          rnd = 1'b0;
    logic [NQ-1:0] nf_force = '0;
    int src_stall = 0, cur_rx_q = 0;
    logic pop_tx_pend = 1'b0, pop_src_pend = 1'b0;
    int host_mode = 0;   // 0 idle, 1 tx, 2 drop, 3 rx
    int host_tx_q = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [CW-1:0] ctrl_of(input int vb);
        int nn;
        nn = (vb == 0) ? CW : vb;
        return CW'(1 << (nn - 1));
    endfunction

    function automatic logic [VBW-1:0] vb_of(input logic [CW-1:0] c);
        int h;
        h = 0;
        for (int k = 0; k < CW; k++) if (c[k]) h = k;
        return VBW'((h + 1) % CW);
    endfunction

    // Environment: fall-through tx FIFO, one active CPU source queue, monitors
    initial begin
        tx_ent_t e;
        logic [CW+DW-1:0] s;
        logic [NQ-1:0] nf, emp, one;
        logic [NQ*DW-1:0] hd;
        logic [NQ*CW-1:0] hc;
        int qi;
        forever begin
            @(posedge clk); #1;
            if (pop_tx_pend && txq.size() > 0) begin
                e = txq.pop_front();
                if (host_mode == 0) begin
                    if (e.is_req && !e.te) begin
                        host_mode = (e.data[QW-1:0] < NQ) ? 1 : 2;
                        host_tx_q = int'(e.data[QW-1:0]);
                    end else if (e.is_req && e.data[QW-1:0] < NQ) begin
                        host_mode = 3;
                    end
                end else if ((host_mode == 1 || host_mode == 2) && e.te) begin
                    host_mode = 0;
                end
            end
            if (pop_src_pend && srcq.size() > 0) begin
                s = srcq.pop_front();
                if (s[DW +: CW] != '0) host_mode = 0;
            end
            pop_tx_pend  = 1'b0;
            pop_src_pend = 1'b0;
            bus.enable_dma         = rnd ? ($urandom_range(3) != 0) : 1'b1;
            bus.rxfifo_nearly_full = rnd ? ($urandom_range(3) == 0) : 1'b0;
            nf = nf_force;
            for (int i = 0; i < NQ; i++) if (rnd && $urandom_range(3) == 0) nf[i] = 1'b1;
            bus.cpu_q_dma_nearly_full = nf;
            if (txq.size() > 0) begin
                e = txq[0];
                bus.txfifo_empty = 1'b0;
            end else begin
                e = tx_ent_t'({$urandom, $urandom});
                bus.txfifo_empty = 1'b1;
            end
            bus.txfifo_rd_is_req      = e.is_req;
            bus.txfifo_rd_pkt_vld     = e.vld;
            bus.txfifo_rd_type_eop    = e.te;
            bus.txfifo_rd_valid_bytes = e.vb;
            bus.txfifo_rd_data        = e.data;
            if (src_stall > 0) src_stall--;
            emp = '1;
            for (int i = 0; i < NQ; i++) begin
                hd[i*DW +: DW] = $urandom;
                hc[i*CW +: CW] = CW'($urandom);
            end
            if (srcq.size() > 0 && src_stall == 0 && !(rnd && $urandom_range(3) == 0)) begin
                emp[cur_rx_q] = 1'b0;
                hd[cur_rx_q*DW +: DW] = srcq[0][DW-1:0];
                hc[cur_rx_q*CW +: CW] = srcq[0][DW +: CW];
            end
            bus.cpu_q_dma_rd_empty = emp;
            bus.cpu_q_dma_rd_data  = hd;
            bus.cpu_q_dma_rd_ctrl  = hc;

            @(negedge clk);
            if (!reset) begin
                if (bus.cpu_q_dma_wr != '0) begin
                    qi = 0;
                    for (int i = 0; i < NQ; i++) if (bus.cpu_q_dma_wr[i]) qi = i;
                    if ($countones(bus.cpu_q_dma_wr) != 1) viol++;
                    got_tx.push_back({QW'(qi), bus.cpu_q_dma_wr_pkt_vld, bus.cpu_q_dma_wr_ctrl,
                                      bus.cpu_q_dma_wr_data});
                end
                if (bus.pkt_ingress) begin
                    cnt_ing++;
                    if (bus.cpu_q_dma_wr == '0 || bus.cpu_q_dma_wr_ctrl == '0) viol++;
                end
                if (bus.pkt_egress) cnt_egr++;
                if (bus.pkt_drop)   cnt_drop++;
                if (bus.req_err)    cnt_err++;
                one = NQ'(1) << cur_rx_q;
                if (bus.rxfifo_wr) begin
                    if (bus.cpu_q_dma_rd != one) viol++;
                    if (bus.cpu_q_dma_rd_empty[cur_rx_q] || bus.rxfifo_nearly_full) viol++;
                    got_rx.push_back({bus.rxfifo_wr_eop, bus.rxfifo_wr_valid_bytes, bus.rxfifo_wr_data});
                    pop_src_pend = 1'b1;
                end else if (bus.cpu_q_dma_rd != '0) begin
                    viol++;
                end
                if (bus.txfifo_rd_inc) begin
                    if (bus.txfifo_empty) viol++;
                    if (host_mode == 1 && bus.cpu_q_dma_nearly_full[host_tx_q]) viol++;
                    if (host_mode == 3) viol++;
                    if (host_mode == 0 && !bus.enable_dma) viol++;
                    pop_tx_pend = 1'b1;
                end
            end
        end
    end

    task automatic step();
        @(negedge clk); #2;
    endtask

    task automatic wait_done();
        int t;
        t = 0;
        while ((txq.size() != 0 || srcq.size() != 0 || host_mode != 0) && t < 2000) begin
            step();
            t++;
        end
        chk("timeout", 64'(t >= 2000), 64'(0));
        repeat (3) step();
    endtask

    task automatic push_req(input int q, input logic rx);
        tx_ent_t e;
        e = '0;
        e.is_req = 1'b1;
        e.te     = rx;
        e.data   = DW'(q);
        txq.push_back(e);
    endtask

    task automatic tx_pkt(input int q, input int n, input logic [DW-1:0] w0, input int vbl,
                          input int nf_hold);
        tx_ent_t e;
        int base, sz1, t;
        push_req(q, 1'b0);
        for (int k = 0; k < n; k++) begin
            e.is_req = 1'b0;
            e.vld    = 1'($urandom);
            e.te     = (k == n - 1);
            e.vb     = (k == n - 1 && vbl >= 0) ? VBW'(vbl) : VBW'($urandom);
            e.data   = (k == 0) ? w0 : DW'($urandom);
            txq.push_back(e);
            if (q < NQ)
                exp_tx.push_back({QW'(q), e.vld, e.te ? ctrl_of(int'(e.vb)) : CW'(0), e.data});
        end
        if (q < NQ) begin
            exp_ing++;
            exp_len = w0[LW-1:0];
        end else begin
            exp_drop++;
        end
        exp_qid = QW'(q);
        if (nf_hold > 0) begin
            base = got_tx.size();
            t = 0;
            while (got_tx.size() == base && t < 200) begin step(); t++; end
            chk("nf_wait_timeout", 64'(t >= 200), 64'(0));
            nf_force[q] = 1'b1;
            step();
            sz1 = got_tx.size();
            repeat (nf_hold - 1) step();
            chk("nf_no_write", 64'(got_tx.size() - sz1), 64'(0));
            nf_force = '0;
        end
        wait_done();
        chk("tx_pkt_qid", 64'(bus.pkt_qid), 64'(exp_qid));
        if (q < NQ) chk("tx_pkt_len", 64'(bus.pkt_len), 64'(exp_len));
    endtask

    task automatic rx_pkt(input int q, input int n, input int stall, input logic [CW-1:0] last_ctrl);
        logic [DW-1:0] d;
        logic [CW-1:0] c;
        if (q < NQ) begin
            cur_rx_q  = q;
            src_stall = stall;
            for (int k = 0; k < n; k++) begin
                d = $urandom;
                c = (k != n - 1) ? CW'(0) : (last_ctrl != '0) ? last_ctrl : CW'($urandom_range(15, 1));
                srcq.push_back({c, d});
                exp_rx.push_back({c != '0, (c != '0) ? vb_of(c) : VBW'(0), d});
                if (k == 0) exp_len = d[LW-1:0];
            end
            exp_egr++;
        end else begin
            exp_err++;
        end
        exp_qid = QW'(q);
        push_req(q, 1'b1);
        wait_done();
        chk("rx_pkt_qid", 64'(bus.pkt_qid), 64'(exp_qid));
        if (q < NQ) chk("rx_pkt_len", 64'(bus.pkt_len), 64'(exp_len));
    endtask

    task automatic stray();
        tx_ent_t e;
        e = tx_ent_t'({$urandom, $urandom});
        e.is_req = 1'b0;
        txq.push_back(e);
        exp_err++;
        wait_done();
        chk("stray_qid", 64'(bus.pkt_qid), 64'(exp_qid));
    endtask

    task automatic compare_all(input string tag);
        int m;
        chk({tag, "_txcount"}, 64'(got_tx.size()), 64'(exp_tx.size()));
        m = (got_tx.size() < exp_tx.size()) ? got_tx.size() : exp_tx.size();
        for (int i = 0; i < m; i++) chk({tag, "_txword"}, 64'(got_tx[i]), 64'(exp_tx[i]));
        chk({tag, "_rxcount"}, 64'(got_rx.size()), 64'(exp_rx.size()));
        m = (got_rx.size() < exp_rx.size()) ? got_rx.size() : exp_rx.size();
        for (int i = 0; i < m; i++) chk({tag, "_rxword"}, 64'(got_rx[i]), 64'(exp_rx[i]));
        chk({tag, "_ingress"}, 64'(cnt_ing), 64'(exp_ing));
        chk({tag, "_egress"},  64'(cnt_egr), 64'(exp_egr));
        chk({tag, "_drop"},    64'(cnt_drop), 64'(exp_drop));
        chk({tag, "_req_err"}, 64'(cnt_err), 64'(exp_err));
        chk({tag, "_protocol"}, 64'(viol), 64'(0));
    endtask

    task automatic check_outputs_zero(input string tag);
        chk({tag, "_wr"},      64'(bus.cpu_q_dma_wr), 64'(0));
        chk({tag, "_wrdata"},  64'({bus.cpu_q_dma_wr_pkt_vld, bus.cpu_q_dma_wr_ctrl, bus.cpu_q_dma_wr_data}), 64'(0));
        chk({tag, "_pulses"},  64'({bus.pkt_ingress, bus.pkt_egress, bus.pkt_drop, bus.req_err}), 64'(0));
        chk({tag, "_qid_len"}, 64'({bus.pkt_qid, bus.pkt_len}), 64'(0));
        chk({tag, "_strobes"}, 64'({bus.txfifo_rd_inc, bus.rxfifo_wr, bus.cpu_q_dma_rd}), 64'(0));
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int kind, t;
        reset = 1'b1;
        repeat (3) step();
        check_outputs_zero("reset");
        reset = 1'b0;
        step();

        // Directed cases from the plan, deterministic flow control
        tx_pkt(5, 3, 32'h40, 2, 0);
        tx_pkt(5, 3, 32'h40, 2, 4);
        tx_pkt(9, 3, 32'h123, -1, 0);
        rx_pkt(2, 2, 5, 4'b1000);
        stray();
        rx_pkt(12, 0, 0, 4'b0000);
        compare_all("directed");

        // Randomized traffic with random back-pressure and enable
        rnd = 1'b1;
        repeat (40) begin
            kind = $urandom_range(9);
            if (kind <= 4)      tx_pkt($urandom_range(NQ - 1), $urandom_range(6, 1), $urandom, -1, 0);
            else if (kind == 5) tx_pkt($urandom_range(15, NQ), $urandom_range(5, 1), $urandom, -1, 0);
            else if (kind <= 7) rx_pkt($urandom_range(NQ - 1), $urandom_range(5, 1), $urandom_range(4), 4'b0000);
            else if (kind == 8) rx_pkt($urandom_range(15, NQ), 0, 0, 4'b0000);
            else                stray();
        end
        compare_all("random");

        // Reset in the middle of a TX packet
        rnd = 1'b0;
        push_req(3, 1'b0);
        for (int k = 0; k < 6; k++) txq.push_back(tx_ent_t'({3'b000, 2'b00, DW'($urandom)}));
        t = 0;
        while (got_tx.size() < 2 && t < 200) begin step(); t++; end
        chk("midtx_timeout", 64'(t >= 200), 64'(0));
        reset = 1'b1;
        txq.delete();
        srcq.delete();
        pop_tx_pend = 1'b0;
        pop_src_pend = 1'b0;
        host_mode = 0;
        step();
        check_outputs_zero("midtx_reset");
        reset = 1'b0;
        got_tx.delete(); exp_tx.delete(); got_rx.delete(); exp_rx.delete();
        cnt_ing = 0; cnt_egr = 0; cnt_drop = 0; cnt_err = 0;
        exp_ing = 0; exp_egr = 0; exp_drop = 0; exp_err = 0;
        step();
        tx_pkt(3, 4, 32'hBEEF, 0, 0);
        compare_all("after_reset");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
